// File: rtl/updown_counter_reg.sv
// updown_counter_reg: registered modulo up/down counter.
// The next count comes from a WIDTH-bit ripple chain of full-adder cells:
// a = count, b = up ? 1 : all-ones, carry-in 0, carry-out discarded.
// Synchronous load (clamped to MOD-1) takes priority over enable.
// tc pulses for one cycle after a wrap, and ovf is a sticky wrap flag.
// Build option SATURATE_EN (macro): the count holds at its bounds instead of
// wrapping. tc then marks reaching a bound, and ovf marks a blocked step.
module updown_counter_reg #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] load_clamp;

  // +1 when counting up; all-ones (i.e. -1 modulo 2**WIDTH) when counting down
  assign b_op     = up ? WIDTH'(1) : {WIDTH{1'b1}};
  assign carry[0] = 1'b0;

  // Ripple chain of full-adder cells; the final carry-out is never formed
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = count_q[i] ^ b_op[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_c
      assign carry[i+1] = (count_q[i] & b_op[i]) | (carry[i] & (count_q[i] ^ b_op[i]));
    end
  end

  assign load_clamp = ({1'b0, load_val} >= MOD_X) ? MAX_C : load_val;

  // Next-state selection: load > en > hold, with wrap/saturate handling and flags
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = load_clamp;
    end else if (en) begin
`ifdef SATURATE_EN
      if (up) begin
        if (count_q >= MAX_C) begin
          count_d = MAX_C;
          ovf_d   = 1'b1;
        end else begin
          count_d = sum;
          tc_d    = (sum == MAX_C);
        end
      end else begin
        if (count_q == '0) begin
          ovf_d = 1'b1;
        end else begin
          count_d = sum;
          tc_d    = (sum == '0);
        end
      end
`else
      if (up) begin
        if (count_q == MAX_C) begin
          count_d = '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else if (count_q > MAX_C) begin
          // Out-of-range state (only reachable by forcing) recovers to zero
          count_d = '0;
        end else begin
          count_d = sum;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_C;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = sum;
        end
      end
`endif
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
